// File: rtl/seg7_bcd_reader.sv
// seg7_bcd_reader: samples an asynchronous 7-segment drive bus, waits for the
// pattern to settle, decodes it back to a BCD digit and offers one report per
// settled pattern change on a one-entry valid/ready buffer with sticky overflow.
module seg7_bcd_reader #(
    parameter bit          ACTIVE_LOW    = 1'b1,
    parameter int unsigned STABLE_CYCLES = 16,
    parameter bit          REPORT_BLANK  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg,
    output logic [3:0] bcd,
    output logic       bcd_err,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       ovf,
    input  logic       clr_ovf
);

    localparam int unsigned      CNT_W     = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
    // Raw line level that means "all segments off" for this polarity.
    localparam logic [6:0]       SEG_BLANK = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [6:0]       LIT_BLANK = 7'h00;

    typedef enum logic {
        HOLD  = 1'b0,
        TRACK = 1'b1
    } state_t;

    logic [6:0]       seg_s1, seg_s2;
    logic [6:0]       lit;
    logic [6:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t           state_q, state_d;
    logic             issue;
    logic             accept;
    logic             drop;
    logic [3:0]       dec_bcd;
    logic             dec_err;

    // Two-flop synchroniser for the asynchronous segment lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1 <= SEG_BLANK;
            seg_s2 <= SEG_BLANK;
        end else begin
            // NOTE: sequential state uses <= so every flop samples the
            // pre-edge value; blocking here would collapse the two stages.
            seg_s1 <= seg;
            seg_s2 <= seg_s1;
        end
    end

    // Normalise polarity so that 1 always means "segment lit".
    assign lit = ACTIVE_LOW ? ~seg_s2 : seg_s2;

    // Decode the settled candidate pattern (abcdefg) into a digit or error code.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; a missing
        // branch would otherwise infer a latch.
        dec_bcd = 4'hE;
        dec_err = 1'b1;
        unique case (cand_q)
            7'b1111110: begin dec_bcd = 4'd0; dec_err = 1'b0; end
            7'b0110000: begin dec_bcd = 4'd1; dec_err = 1'b0; end
            7'b1101101: begin dec_bcd = 4'd2; dec_err = 1'b0; end
            7'b1111001: begin dec_bcd = 4'd3; dec_err = 1'b0; end
            7'b0110011: begin dec_bcd = 4'd4; dec_err = 1'b0; end
            7'b1011011: begin dec_bcd = 4'd5; dec_err = 1'b0; end
            7'b1011111: begin dec_bcd = 4'd6; dec_err = 1'b0; end
            7'b1110000: begin dec_bcd = 4'd7; dec_err = 1'b0; end
            7'b1111111: begin dec_bcd = 4'd8; dec_err = 1'b0; end
            7'b1111011: begin dec_bcd = 4'd9; dec_err = 1'b0; end
            7'b0000000: begin dec_bcd = 4'hF; dec_err = 1'b0; end
            default:    begin dec_bcd = 4'hE; dec_err = 1'b1; end
        endcase
    end

    // Filter state register: candidate pattern, stability count and FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HOLD;
            cand_q  <= LIT_BLANK;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: any change restarts the count; a full stable run
    // issues exactly one report and parks in HOLD until the pattern moves.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        issue   = 1'b0;
        if (lit != cand_q) begin
            cand_d  = lit;
            cnt_d   = '0;
            state_d = TRACK;
        end else if (state_q == TRACK) begin
            if (cnt_q == CNT_LAST) begin
                // Counter stays at the compare point rather than wrapping.
                state_d = HOLD;
                issue   = REPORT_BLANK || (cand_q != LIT_BLANK);
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign accept = out_valid && out_ready;
    // A report arriving while the consumer is still holding the previous one
    // is lost; the held report is never overwritten.
    assign drop   = issue && out_valid && !out_ready;

    // One-entry output buffer; an accept and issue on the same edge reloads
    // without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            bcd       <= 4'h0;
            bcd_err   <= 1'b0;
        end else if (issue && !drop) begin
            out_valid <= 1'b1;
            bcd       <= dec_bcd;
            bcd_err   <= dec_err;
        end else if (accept) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky overflow flag; a drop on the same edge as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg7_bcd_reader.sv
// tb_seg7_bcd_reader: randomized and directed stimulus for seg7_bcd_reader.
// A reference model predicts reports from run lengths of the applied pattern;
// a monitor compares the DUT output buffer against the expected queue.
module tb_seg7_bcd_reader;

    localparam int STABLE = 16;

    typedef struct packed {
        logic [3:0] bcd;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] seg;
    logic       out_ready;
    logic       clr_ovf;
    logic [3:0] bcd;
    logic       bcd_err;
    logic       out_valid;
    logic       ovf;
    logic [3:0] bcd_nb;
    logic       err_nb;
    logic       valid_nb;
    logic       ovf_nb;

    int checks   = 0;
    int failures = 0;

    logic [6:0] digit_lit [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                   7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                   7'b1111111, 7'b1111011};

    always #5 clk = ~clk;

    seg7_bcd_reader #(.ACTIVE_LOW(1'b1), .STABLE_CYCLES(STABLE), .REPORT_BLANK(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .seg(seg), .bcd(bcd), .bcd_err(bcd_err),
        .out_valid(out_valid), .out_ready(out_ready), .ovf(ovf), .clr_ovf(clr_ovf)
    );

    seg7_bcd_reader #(.ACTIVE_LOW(1'b1), .STABLE_CYCLES(STABLE), .REPORT_BLANK(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .seg(seg), .bcd(bcd_nb), .bcd_err(err_nb),
        .out_valid(valid_nb), .out_ready(1'b1), .ovf(ovf_nb), .clr_ovf(1'b0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t ref_decode(input logic [6:0] p);
        exp_t r;
        r = '{bcd: 4'hE, err: 1'b1};
        if (p == 7'd0) r = '{bcd: 4'hF, err: 1'b0};
        for (int i = 0; i < 10; i++)
            if (digit_lit[i] == p) r = '{bcd: 4'(i), err: 1'b0};
        return r;
    endfunction

    // ---------------- reference model ----------------
    exp_t       exp_q[$];
    exp_t       nb_q[$];
    logic [6:0] cur_lit = 7'd0;
    int         run_len = 0;
    bit         settled = 1'b1;
    bit         pipe_v[2] = '{1'b0, 1'b0};
    logic [6:0] pipe_p[2] = '{7'd0, 7'd0};
    bit         mvalid = 1'b0;
    bit         movf = 1'b0;
    bit         m_issue, m_drop;
    logic [6:0] m_pat, m_lit;

    // A pattern seen on STABLE+1 consecutive edges is reported two edges later
    // (synchroniser delay); the buffer then follows the valid/ready rules.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_lit = 7'd0; run_len = 0; settled = 1'b1;
            pipe_v[0] = 1'b0; pipe_v[1] = 1'b0;
            exp_q.delete(); nb_q.delete();
            mvalid = 1'b0; movf = 1'b0;
        end else begin
            m_issue = pipe_v[1];
            m_pat   = pipe_p[1];
            pipe_v[1] = pipe_v[0]; pipe_p[1] = pipe_p[0]; pipe_v[0] = 1'b0;
            m_lit = ~seg;
            if (m_lit == cur_lit) begin
                if (run_len < 100000) run_len++;
            end else begin
                cur_lit = m_lit; run_len = 1; settled = 1'b0;
            end
            if (!settled && run_len == STABLE + 1) begin
                settled = 1'b1; pipe_v[0] = 1'b1; pipe_p[0] = cur_lit;
            end
            m_drop = 1'b0;
            if (m_issue) begin
                if (m_pat != 7'd0) nb_q.push_back(ref_decode(m_pat));
                if (!mvalid || out_ready) begin
                    exp_q.push_back(ref_decode(m_pat));
                    mvalid = 1'b1;
                end else begin
                    m_drop = 1'b1;
                    movf = 1'b1;
                end
            end else if (mvalid && out_ready) begin
                mvalid = 1'b0;
            end
            if (clr_ovf && !m_drop) movf = 1'b0;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        check("out_valid", out_valid, mvalid);
        check("ovf", ovf, movf);
        if (out_valid) begin
            check("report_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                check("bcd", bcd, exp_q[0].bcd);
                check("bcd_err", bcd_err, exp_q[0].err);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
        check("nb_ovf", ovf_nb, 0);
        if (valid_nb) begin
            check("nb_report_expected", nb_q.size() != 0, 1);
            if (nb_q.size() != 0) begin
                check("nb_bcd", bcd_nb, nb_q[0].bcd);
                check("nb_err", err_nb, nb_q[0].err);
                void'(nb_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic hold(input logic [6:0] l, input int n);
        seg = ~l;
        repeat (n) step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   dur;
        int   kind;
        logic [6:0] pat;

        rst_n = 1'b0; seg = 7'h7F; out_ready = 1'b1; clr_ovf = 1'b0;
        repeat (3) step();
        check("rst_bcd", bcd, 0);
        check("rst_err", bcd_err, 0);
        check("rst_valid", out_valid, 0);
        check("rst_ovf", ovf, 0);
        rst_n = 1'b1;

        // 1) blank stays silent
        hold(7'd0, 50);
        // 2) digit 1, single report then quiet
        hold(digit_lit[1], 118);
        // 3) walk the digits
        for (int d = 0; d < 10; d++) hold(digit_lit[d], 40);
        // 4) glitch restarts the count
        hold(digit_lit[8], 10);
        hold(digit_lit[0], 1);
        hold(digit_lit[8], 40);
        // 5) overflow with consumer stalled, then clear and drain
        out_ready = 1'b0;
        hold(digit_lit[3], 40);
        hold(digit_lit[5], 40);
        check("ovf_set", ovf, 1);
        check("held_bcd", bcd, 3);
        clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
        check("ovf_cleared", ovf, 0);
        out_ready = 1'b1;
        step();
        check("drained", out_valid, 0);
        hold(digit_lit[5], 10);
        // 6) error pattern, then reset while a report is pending
        out_ready = 1'b0;
        seg = ~7'b1000001;
        for (int i = 0; i < 60; i++) begin
            if (out_valid) break;
            step();
        end
        check("wait_valid", out_valid, 1);
        check("err_bcd", bcd, 4'hE);
        check("err_flag", bcd_err, 1);
        seg = ~digit_lit[7];
        rst_n = 1'b0;
        #1;
        check("valid_async_clear", out_valid, 0);
        step(); step(); step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        hold(digit_lit[7], 40);
        hold(7'd0, 40);

        // randomized runs with random back-pressure and ovf clears
        for (int r = 0; r < 80; r++) begin
            kind = $urandom_range(0, 19);
            if (kind < 12)      pat = digit_lit[$urandom_range(0, 9)];
            else if (kind < 15) pat = 7'd0;
            else                pat = 7'($urandom_range(0, 127));
            dur = (kind % 3 == 0) ? $urandom_range(1, 6) : $urandom_range(14, 40);
            seg = ~pat;
            for (int c = 0; c < dur; c++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                clr_ovf   = ($urandom_range(0, 15) == 0);
                step();
            end
        end

        // drain everything outstanding
        out_ready = 1'b1; clr_ovf = 1'b0;
        hold(7'd0, 60);
        check("exp_q_empty", exp_q.size(), 0);
        check("nb_q_empty", nb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
